ahb_classifier_slave: RTL and testbench
=======================================

Name: ahb_classifier_slave

Overview:
AHB-Lite subordinate that terminates the classifier host bus and is the counterpart of the bus-driving master. It decodes address/data phases and holds the CTRL and CFG registers. It turns pixel-window writes into single-cycle pixel write strobes to the R/G/B image buffers, and returns STATUS and RESULT from the classifier core. It sits between the AHB-Lite interconnect and the classifier core / image RAMs.

Parameters:
BASE_ADDR, 16'h8000, required value of HADDR[31:16]; any other value returns ERROR.
PIX_AW, 10, pixel index width; each channel window is 2**PIX_AW bytes (32x32 image).
LABEL_W, 5, width of the class label (24 classes).

Ports:
clk  in  1  system clock
resetn  in  1  reset, asynchronous assert, active-low
ahb_haddr_i  in  32  address phase address
ahb_hwrite_i  in  1  1=write
ahb_hsize_i  in  3  transfer size
ahb_htrans_i  in  2  IDLE/BUSY/NSEQ/SEQ
ahb_hwdata_i  in  32  write data (data phase)
ahb_hready_o  out  1  transfer done / ready
ahb_hresp_o  out  1  0=OKAY, 1=ERROR
ahb_hrdata_o  out  32  read data (data phase)
cfg_o  out  32  CFG register
start_o  out  1  one-cycle classifier start pulse
pix_we_o  out  1  pixel write strobe, one cycle
pix_ch_o  out  2  0=R, 1=G, 2=B
pix_addr_o  out  PIX_AW  pixel index
pix_data_o  out  8  pixel byte
done_i  in  1  one-cycle classification-complete pulse
label_i  in  LABEL_W  label, valid with done_i

Behaviour:
- Reset values: hready_o=1, hresp_o=0, hrdata_o=0, cfg_o=0, start_o=0, pix_we_o=0, pix_ch_o=0, pix_addr_o=0, pix_data_o=0; internal busy=0, done=0, overrun=0, result=0; FSM=IDLE.
- Address phase is accepted when htrans is NSEQ or SEQ and hready_o=1. The slave registers addr, write, size and a decode class. IDLE and BUSY are ignored and get a zero-wait OKAY.
- Memory map, offsets within BASE_ADDR:
  - 0x0000 CTRL: W, bit0=1 requests start. Reads as 0.
  - 0x0004 CFG: R/W, 32 bits.
  - 0x1000 STATUS: RO. bit0=done (sticky), bit1=busy, bit2=overrun (sticky). Other bits 0.
  - 0x1004 RESULT: RO. [LABEL_W-1:0]=last label, upper bits 0.
  - 0x2000-0x23FF R window, 0x2400-0x27FF G window, 0x2800-0x2BFF B window. Write-only; reads return 0 with OKAY.
- Decode errors: any other offset, HADDR[31:16]!=BASE_ADDR, hsize>3'b010, a write to STATUS/RESULT, or a register access whose HADDR[1:0]!=0. Byte-addressed pixel windows are exempt from the alignment check.
- FSM states:
  - IDLE: no transfer in data phase.
  - DATA: data phase of a valid transfer. Zero wait, hready_o=1, hresp_o=0.
  - ERR1: hready_o=0, hresp_o=1.
  - ERR2: hready_o=1, hresp_o=1, then IDLE, or a new address phase is accepted.
  - The two-cycle ERROR response follows the AHB-Lite rule. A faulting access has no side effects.
- Writes: data is captured from ahb_hwdata_i in the DATA cycle.
  - CFG updates at the end of that cycle.
  - A pixel write drives pix_we_o=1 for exactly one cycle on the clock edge ending DATA, with pix_ch_o=offset[11:10], pix_addr_o=offset[9:0], pix_data_o=hwdata[7:0].
- Reads: hrdata_o is valid during DATA, combinationally selected from the registered address. Read latency is zero wait states.
- Start:
  - A CTRL write with bit0=1 while busy=0 gives start_o=1 for one cycle, busy=1, done=0.
  - The same write while busy=1 does not pulse start_o and sets overrun=1.
  - A CTRL write with bit0=0 has no effect.
- done_i=1 sets done=1, clears busy and captures label_i into RESULT.
- Simultaneous done_i and a starting CTRL write in the same cycle: done_i is processed first, then the start is accepted. Result: busy=1, done=0, RESULT updated, start_o pulses.
- overrun clears only on a CTRL write with bit0=1 while busy=0.
- Back-to-back pipelined transfers (a new NSEQ during DATA) are accepted with no bubble.
- resetn deasserted mid-transfer: all state returns to reset values immediately. A pending pixel strobe is dropped.

Decomposition:
- Shared package ahb_lite_pkg holds the HTRANS_* and HSIZE_* constants and the response constants OKAY/ERROR.
- The same package holds the offset constants CTRL_OFS, CFG_OFS, STATUS_OFS, RESULT_OFS, PIX_R_OFS, PIX_G_OFS, PIX_B_OFS and an enum for decode class {REG_CTRL, REG_CFG, REG_STATUS, REG_RESULT, PIX, BAD}.
- One sub-module, ahb_addr_decoder, is purely combinational: address/size/write in, decode class and channel out. All FSM and register state stays in the top.

Test Plan:
- Write 0x8000_0004 with 32'd32, then read it back: cfg_o=32, read returns 0x20, hresp_o=0, no wait states.
- Write 0x8000_2405 with 0xA7: exactly one pix_we_o cycle with ch=1, addr=5, data=0xA7. No other pix_we_o cycles occur.
- Write CTRL=1 -> start_o pulses once and STATUS reads 0x2. Assert done_i with label_i=13 -> STATUS=0x1 and RESULT=13.
- Write CTRL=1 while busy -> no start_o and STATUS bit2=1. A later CTRL=1 when idle clears overrun and starts.
- Read 0x8000_3000 and write 0x9000_0000 -> two-cycle ERROR (hready 0 then 1, hresp 1). cfg_o and pix_we_o are unchanged.
- done_i in the same cycle as a CTRL=1 write while busy -> start_o=1, busy=1, done=0, RESULT updated. Reset asserted mid-write -> all outputs return to reset values.

Source files
------------

// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite encodings and the classifier slave memory map.
// Imported by the address decoder and the slave top.
package ahb_lite_pkg;

  localparam logic [1:0] HTRANS_IDLE = 2'b00;
  localparam logic [1:0] HTRANS_BUSY = 2'b01;
  localparam logic [1:0] HTRANS_NSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ  = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic OKAY  = 1'b0;
  localparam logic ERROR = 1'b1;

  localparam logic [15:0] CTRL_OFS   = 16'h0000;
  localparam logic [15:0] CFG_OFS    = 16'h0004;
  localparam logic [15:0] STATUS_OFS = 16'h1000;
  localparam logic [15:0] RESULT_OFS = 16'h1004;
  localparam logic [15:0] PIX_R_OFS  = 16'h2000;
  localparam logic [15:0] PIX_G_OFS  = 16'h2400;
  localparam logic [15:0] PIX_B_OFS  = 16'h2800;

  typedef enum logic [2:0] {
    REG_CTRL   = 3'd0,
    REG_CFG    = 3'd1,
    REG_STATUS = 3'd2,
    REG_RESULT = 3'd3,
    PIX        = 3'd4,
    BAD        = 3'd5
  } dec_class_e;

  // NSEQ and SEQ both carry a real transfer; IDLE and BUSY do not.
  function automatic logic htrans_active(input logic [1:0] htrans);
    return (htrans == HTRANS_NSEQ) || (htrans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahb_addr_decoder.sv
// Combinational address-phase decoder: classifies a transfer and extracts
// the pixel channel and index for the R/G/B windows.
module ahb_addr_decoder
  import ahb_lite_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'h8000,
  parameter int          PIX_AW    = 10
) (
  input  logic [31:0]       haddr,
  input  logic [2:0]        hsize,
  input  logic              hwrite,
  output dec_class_e        dec_class,
  output logic [1:0]        pix_ch,
  output logic [PIX_AW-1:0] pix_idx
);

  // The three channel windows are contiguous starting at the R window.
  localparam logic [15:0] PIX_SPAN = 16'(3 << PIX_AW);

  logic [15:0] ofs_s;
  logic [15:0] ofs_rel_s;
  logic        in_pix_s;

  assign ofs_s     = haddr[15:0];
  assign ofs_rel_s = ofs_s - PIX_R_OFS;
  assign in_pix_s  = (ofs_s >= PIX_R_OFS) && (ofs_rel_s < PIX_SPAN);
  assign pix_ch    = ofs_rel_s[PIX_AW+1:PIX_AW];
  assign pix_idx   = ofs_rel_s[PIX_AW-1:0];

  // Classify the address phase; exact offset matches make misaligned register hits fall to BAD.
  always_comb begin
    dec_class = BAD;
    if ((haddr[31:16] != BASE_ADDR) || (hsize > HSIZE_WORD)) begin
      dec_class = BAD;
    end else if (in_pix_s) begin
      dec_class = PIX;
    end else begin
      case (ofs_s)
        CTRL_OFS:   dec_class = REG_CTRL;
        CFG_OFS:    dec_class = REG_CFG;
        STATUS_OFS: dec_class = hwrite ? BAD : REG_STATUS;
        RESULT_OFS: dec_class = hwrite ? BAD : REG_RESULT;
        default:    dec_class = BAD;
      endcase
    end
  end

endmodule

// File: rtl/ahb_classifier_slave.sv
// AHB-Lite slave for the classifier: CTRL/CFG/STATUS/RESULT registers and
// pixel-window writes turned into one-cycle image-buffer strobes.
module ahb_classifier_slave
  import ahb_lite_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'h8000,
  parameter int          PIX_AW    = 10,
  parameter int          LABEL_W   = 5
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [31:0]        ahb_haddr_i,
  input  logic               ahb_hwrite_i,
  input  logic [2:0]         ahb_hsize_i,
  input  logic [1:0]         ahb_htrans_i,
  input  logic [31:0]        ahb_hwdata_i,
  output logic               ahb_hready_o,
  output logic               ahb_hresp_o,
  output logic [31:0]        ahb_hrdata_o,
  output logic [31:0]        cfg_o,
  output logic               start_o,
  output logic               pix_we_o,
  output logic [1:0]         pix_ch_o,
  output logic [PIX_AW-1:0]  pix_addr_o,
  output logic [7:0]         pix_data_o,
  input  logic               done_i,
  input  logic [LABEL_W-1:0] label_i
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } state_e;

  state_e             state_r;
  state_e             state_s;
  dec_class_e         dec_class_s;
  dec_class_e         dec_class_r;
  logic [1:0]         dec_ch_s;
  logic [1:0]         dec_ch_r;
  logic [PIX_AW-1:0]  dec_idx_s;
  logic [PIX_AW-1:0]  dec_idx_r;
  logic               write_r;
  logic               accept_s;
  logic               wr_data_s;
  logic               start_req_s;
  logic               pix_wr_s;
  logic               busy_r;
  logic               busy_s;
  logic               done_r;
  logic               done_s;
  logic               overrun_r;
  logic               overrun_s;
  logic [LABEL_W-1:0] result_r;
  logic [LABEL_W-1:0] result_s;
  logic               start_s;

  ahb_addr_decoder #(
    .BASE_ADDR (BASE_ADDR),
    .PIX_AW    (PIX_AW)
  ) u_dec (
    .haddr     (ahb_haddr_i),
    .hsize     (ahb_hsize_i),
    .hwrite    (ahb_hwrite_i),
    .dec_class (dec_class_s),
    .pix_ch    (dec_ch_s),
    .pix_idx   (dec_idx_s)
  );

  assign accept_s    = htrans_active(ahb_htrans_i) && ahb_hready_o;
  assign wr_data_s   = (state_r == ST_DATA) && write_r;
  assign start_req_s = wr_data_s && (dec_class_r == REG_CTRL) && ahb_hwdata_i[0];
  assign pix_wr_s    = wr_data_s && (dec_class_r == PIX);

  // Transfer state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next state: a faulting access is never allowed into DATA, so it has no side effects.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_ERR1: state_s = ST_ERR2;
      ST_IDLE, ST_DATA, ST_ERR2: begin
        if (accept_s) begin
          state_s = (dec_class_s == BAD) ? ST_ERR1 : ST_DATA;
        end else begin
          state_s = ST_IDLE;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Response signalling decoded from the registered state.
  always_comb begin
    ahb_hready_o = 1'b1;
    ahb_hresp_o  = OKAY;
    case (state_r)
      ST_ERR1: begin
        ahb_hready_o = 1'b0;
        ahb_hresp_o  = ERROR;
      end
      ST_ERR2: begin
        ahb_hready_o = 1'b1;
        ahb_hresp_o  = ERROR;
      end
      default: begin
        ahb_hready_o = 1'b1;
        ahb_hresp_o  = OKAY;
      end
    endcase
  end

  // Address-phase capture for the following data phase.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dec_class_r <= REG_CTRL;
      dec_ch_r    <= 2'd0;
      dec_idx_r   <= '0;
      write_r     <= 1'b0;
    end else if (accept_s) begin
      dec_class_r <= dec_class_s;
      dec_ch_r    <= dec_ch_s;
      dec_idx_r   <= dec_idx_s;
      write_r     <= ahb_hwrite_i;
    end else begin
      write_r     <= write_r;
    end
  end

  // Read data mux, valid only in the data phase of a read.
  always_comb begin
    ahb_hrdata_o = 32'd0;
    if ((state_r == ST_DATA) && !write_r) begin
      case (dec_class_r)
        REG_CFG:    ahb_hrdata_o = cfg_o;
        REG_STATUS: ahb_hrdata_o = {29'd0, overrun_r, busy_r, done_r};
        REG_RESULT: ahb_hrdata_o = {{(32-LABEL_W){1'b0}}, result_r};
        default:    ahb_hrdata_o = 32'd0;
      endcase
    end else begin
      ahb_hrdata_o = 32'd0;
    end
  end

  // Classifier handshake: completion is applied before a same-cycle start request.
  always_comb begin
    busy_s    = busy_r;
    done_s    = done_r;
    overrun_s = overrun_r;
    result_s  = result_r;
    start_s   = 1'b0;
    if (done_i) begin
      done_s   = 1'b1;
      busy_s   = 1'b0;
      result_s = label_i;
    end else begin
      done_s   = done_r;
    end
    if (start_req_s) begin
      if (!busy_s) begin
        start_s   = 1'b1;
        busy_s    = 1'b1;
        done_s    = 1'b0;
        overrun_s = 1'b0;
      end else begin
        overrun_s = 1'b1;
      end
    end else begin
      start_s = 1'b0;
    end
  end

  // Classifier status registers and start pulse.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      overrun_r <= 1'b0;
      result_r  <= '0;
      start_o   <= 1'b0;
    end else begin
      busy_r    <= busy_s;
      done_r    <= done_s;
      overrun_r <= overrun_s;
      result_r  <= result_s;
      start_o   <= start_s;
    end
  end

  // CFG register and pixel write strobe, both launched on the edge ending DATA.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cfg_o      <= 32'd0;
      pix_we_o   <= 1'b0;
      pix_ch_o   <= 2'd0;
      pix_addr_o <= '0;
      pix_data_o <= 8'd0;
    end else begin
      if (wr_data_s && (dec_class_r == REG_CFG)) begin
        cfg_o <= ahb_hwdata_i;
      end
      pix_we_o <= pix_wr_s;
      if (pix_wr_s) begin
        pix_ch_o   <= dec_ch_r;
        pix_addr_o <= dec_idx_r;
        pix_data_o <= ahb_hwdata_i[7:0];
      end
    end
  end

endmodule

// File: tb/tb_ahb_classifier_slave.sv
// Self-checking bench for ahb_classifier_slave: directed scenarios plus
// randomized transfers checked against a memory-map level reference model.
`timescale 1ns/1ps
module tb_ahb_classifier_slave;

  localparam logic [1:0] T_IDLE = 2'b00;
  localparam logic [1:0] T_NSEQ = 2'b10;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] haddr = 32'd0;
  logic        hwrite = 1'b0;
  logic [2:0]  hsize = 3'd0;
  logic [1:0]  htrans = T_IDLE;
  logic [31:0] hwdata = 32'd0;
  logic        hready, hresp;
  logic [31:0] hrdata, cfg;
  logic        start, pix_we;
  logic [1:0]  pix_ch;
  logic [9:0]  pix_addr;
  logic [7:0]  pix_data;
  logic        done_in = 1'b0;
  logic [4:0]  label_in = 5'd0;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: register-level view of the slave
  logic [31:0] m_cfg = 32'd0;
  bit          m_busy = 1'b0, m_done = 1'b0, m_ovr = 1'b0;
  logic [4:0]  m_result = 5'd0;
  int          m_starts = 0;
  logic [19:0] m_pix[$];

  logic [19:0] pix_q[$];
  int          start_cnt = 0;

  always #5 clk = ~clk;

  ahb_classifier_slave dut (
    .clk(clk), .resetn(resetn),
    .ahb_haddr_i(haddr), .ahb_hwrite_i(hwrite), .ahb_hsize_i(hsize),
    .ahb_htrans_i(htrans), .ahb_hwdata_i(hwdata),
    .ahb_hready_o(hready), .ahb_hresp_o(hresp), .ahb_hrdata_o(hrdata),
    .cfg_o(cfg), .start_o(start), .pix_we_o(pix_we), .pix_ch_o(pix_ch),
    .pix_addr_o(pix_addr), .pix_data_o(pix_data),
    .done_i(done_in), .label_i(label_in)
  );

  always @(negedge clk) begin
    if (pix_we === 1'b1) pix_q.push_back({pix_ch, pix_addr, pix_data});
    if (start === 1'b1) start_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic model_step(input logic [31:0] a, input bit w, input logic [2:0] sz,
                            input logic [31:0] wd, input bit dp, input logic [4:0] lbl,
                            output bit e, output logic [31:0] rd);
    int unsigned ofs, rel;
    ofs = a[15:0];
    e = 1'b1;
    if (a[31:16] == 16'h8000 && sz <= 3'd2) begin
      if (ofs >= 32'h2000 && ofs < 32'h2C00) e = 1'b0;
      else if (ofs == 32'h0 || ofs == 32'h4) e = 1'b0;
      else if (ofs == 32'h1000 || ofs == 32'h1004) e = w;
    end
    rd = 32'd0;
    if (!e && !w) begin
      if (ofs == 32'h4) rd = m_cfg;
      else if (ofs == 32'h1000) rd = 32'(m_ovr) * 4 + 32'(m_busy) * 2 + 32'(m_done);
      else if (ofs == 32'h1004) rd = 32'(m_result);
    end
    if (dp) begin
      m_done = 1'b1; m_busy = 1'b0; m_result = lbl;
    end
    if (!e && w) begin
      if (ofs == 32'h4) m_cfg = wd;
      else if (ofs == 32'h0 && wd[0]) begin
        if (m_busy) m_ovr = 1'b1;
        else begin m_starts++; m_busy = 1'b1; m_done = 1'b0; m_ovr = 1'b0; end
      end else if (ofs >= 32'h2000) begin
        rel = ofs - 32'h2000;
        m_pix.push_back({2'(rel / 1024), 10'(rel % 1024), wd[7:0]});
      end
    end
  endtask

  task automatic ahb_xfer(input logic [31:0] a, input bit w, input logic [2:0] sz,
                          input logic [31:0] wd, input bit dp, input logic [4:0] lbl,
                          output logic [31:0] rd, output bit err, output bit ok);
    @(posedge clk); #1;
    haddr = a; hwrite = w; hsize = sz; htrans = T_NSEQ;
    @(posedge clk); #1;
    htrans = T_IDLE; haddr = 32'd0; hwdata = wd;
    done_in = dp; label_in = lbl;
    @(negedge clk);
    rd = hrdata; err = (hresp === 1'b1); ok = 1'b1;
    if (err) begin
      if (hready !== 1'b0) ok = 1'b0;
      @(posedge clk); #1; done_in = 1'b0;
      @(negedge clk);
      if (hready !== 1'b1 || hresp !== 1'b1) ok = 1'b0;
    end else if (hready !== 1'b1 || hresp !== 1'b0) ok = 1'b0;
    @(posedge clk); #1; done_in = 1'b0;
  endtask

  task automatic do_xfer(input logic [31:0] a, input bit w, input logic [2:0] sz,
                         input logic [31:0] wd, input bit dp, input logic [4:0] lbl,
                         output logic [31:0] rd, output bit err, output bit ok,
                         output bit e_err, output logic [31:0] e_rd);
    model_step(a, w, sz, wd, dp, lbl, e_err, e_rd);
    ahb_xfer(a, w, sz, wd, dp, lbl, rd, err, ok);
  endtask

  task automatic pulse_done(input logic [4:0] lbl);
    @(posedge clk); #1; done_in = 1'b1; label_in = lbl;
    @(posedge clk); #1; done_in = 1'b0;
    m_done = 1'b1; m_busy = 1'b0; m_result = lbl;
  endtask

  task automatic test_reset();
    logic [31:0] rd, erd; bit er, ok, eer;
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({hready, hresp, hrdata, cfg, start, pix_we, pix_ch, pix_addr, pix_data} !== {1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 2'd0, 10'd0, 8'd0}) begin
      n_bad++;
      $display("FAIL reset_outputs: got hready=%b hresp=%b hrdata=%h cfg=%h start=%b we=%b ch=%0d addr=%0d data=%h, want 1 0 0 0 0 0 0 0 0",
               hready, hresp, hrdata, cfg, start, pix_we, pix_ch, pix_addr, pix_data);
    end
    @(posedge clk); #1; resetn = 1'b1;
    do_xfer(32'h8000_1000, 1'b0, 3'd2, 32'd0, 1'b0, 5'd0, rd, er, ok, eer, erd);
    n_cmp++;
    if (er || !ok || rd !== 32'd0) begin n_bad++; $display("FAIL reset_status: got rd=%h err=%b ok=%b, want 0 0 1", rd, er, ok); end
  endtask

  task automatic test_cfg();
    logic [31:0] rd, erd; bit er, ok, eer;
    do_xfer(32'h8000_0004, 1'b1, 3'd2, 32'd32, 1'b0, 5'd0, rd, er, ok, eer, erd);
    n_cmp++;
    if (er || !ok) begin n_bad++; $display("FAIL cfg_wr_resp: got err=%b ok=%b, want 0 1", er, ok); end
    n_cmp++;
    if (cfg !== 32'd32) begin n_bad++; $display("FAIL cfg_o: got %h want %h", cfg, 32'd32); end
    do_xfer(32'h8000_0004, 1'b0, 3'd2, 32'd0, 1'b0, 5'd0, rd, er, ok, eer, erd);
    n_cmp++;
    if (er || !ok || rd !== 32'h20) begin n_bad++; $display("FAIL cfg_readback: got rd=%h err=%b ok=%b, want 20 0 1", rd, er, ok); end
  endtask

  task automatic test_pixel();
    logic [31:0] rd, erd; bit er, ok, eer;
    pix_q.delete(); m_pix.delete();
    do_xfer(32'h8000_2405, 1'b1, 3'd0, 32'h0000_00A7, 1'b0, 5'd0, rd, er, ok, eer, erd);
    repeat (3) @(posedge clk); #1;
    n_cmp++;
    if (er || !ok) begin n_bad++; $display("FAIL pix_wr_resp: got err=%b ok=%b, want 0 1", er, ok); end
    n_cmp++;
    if (pix_q.size() != 1) begin n_bad++; $display("FAIL pix_count: got %0d strobes want 1", pix_q.size()); end
    else if (pix_q[0] !== {2'd1, 10'd5, 8'hA7}) begin
      n_bad++; $display("FAIL pix_fields: got ch=%0d addr=%0d data=%h, want 1 5 a7", pix_q[0][19:18], pix_q[0][17:8], pix_q[0][7:0]);
    end
    pix_q.delete(); m_pix.delete();
  endtask

  task automatic test_start_done();
    logic [31:0] rd, erd; bit er, ok, eer; int s0;
    s0 = start_cnt;
    do_xfer(32'h8000_0000, 1'b1, 3'd2, 32'd1, 1'b0, 5'd0, rd, er, ok, eer, erd);
    repeat (2) @(posedge clk); #1;
    n_cmp++;
    if (start_cnt != s0 + 1) begin n_bad++; $display("FAIL start_pulse: got %0d pulses want 1", start_cnt - s0); end
    do_xfer(32'h8000_1000, 1'b0, 3'd2, 32'd0, 1'b0, 5'd0, rd, er, ok, eer, erd);
    n_cmp++;
    if (er || rd !== 32'h2) begin n_bad++; $display("FAIL status_busy: got %h want 2", rd); end
    pulse_done(5'd13);
    do_xfer(32'h8000_1000, 1'b0, 3'd2, 32'd0, 1'b0, 5'd0, rd, er, ok, eer, erd);
    n_cmp++;
    if (er || rd !== 32'h1) begin n_bad++; $display("FAIL status_done: got %h want 1", rd); end
    do_xfer(32'h8000_1004, 1'b0, 3'd2, 32'd0, 1'b0, 5'd0, rd, er, ok, eer, erd);
    n_cmp++;
    if (er || rd !== 32'd13) begin n_bad++; $display("FAIL result: got %h want d", rd); end
  endtask

  task automatic test_overrun();
    logic [31:0] rd, erd; bit er, ok, eer; int s0;
    s0 = start_cnt;
    do_xfer(32'h8000_0000, 1'b1, 3'd2, 32'd1, 1'b0, 5'd0, rd, er, ok, eer, erd);
    do_xfer(32'h8000_0000, 1'b1, 3'd2, 32'd1, 1'b0, 5'd0, rd, er, ok, eer, erd);
    do_xfer(32'h8000_1000, 1'b0, 3'd2, 32'd0, 1'b0, 5'd0, rd, er, ok, eer, erd);
    n_cmp++;
    if (rd !== 32'h6) begin n_bad++; $display("FAIL status_overrun: got %h want 6", rd); end
    n_cmp++;
    if (start_cnt != s0 + 1) begin n_bad++; $display("FAIL overrun_no_start: got %0d pulses want 1", start_cnt - s0); end
    do_xfer(32'h8000_0000, 1'b1, 3'd2, 32'd0, 1'b0, 5'd0, rd, er, ok, eer, erd);
    pulse_done(5'd7);
    do_xfer(32'h8000_1000, 1'b0, 3'd2, 32'd0, 1'b0, 5'd0, rd, er, ok, eer, erd);
    n_cmp++;
    if (rd !== 32'h5) begin n_bad++; $display("FAIL status_sticky: got %h want 5", rd); end
    do_xfer(32'h8000_0000, 1'b1, 3'd2, 32'd1, 1'b0, 5'd0, rd, er, ok, eer, erd);
    do_xfer(32'h8000_1000, 1'b0, 3'd2, 32'd0, 1'b0, 5'd0, rd, er, ok, eer, erd);
    n_cmp++;
    if (rd !== 32'h2 || start_cnt != s0 + 2) begin
      n_bad++; $display("FAIL overrun_clear: got status=%h pulses=%0d, want 2 and 2", rd, start_cnt - s0);
    end
  endtask

  task automatic test_done_with_start();
    logic [31:0] rd, erd; bit er, ok, eer; int s0;
    s0 = start_cnt;
    do_xfer(32'h8000_0000, 1'b1, 3'd2, 32'd1, 1'b1, 5'd21, rd, er, ok, eer, erd);
    repeat (2) @(posedge clk); #1;
    n_cmp++;
    if (start_cnt != s0 + 1) begin n_bad++; $display("FAIL same_cycle_start: got %0d pulses want 1", start_cnt - s0); end
    do_xfer(32'h8000_1000, 1'b0, 3'd2, 32'd0, 1'b0, 5'd0, rd, er, ok, eer, erd);
    n_cmp++;
    if (rd !== 32'h2) begin n_bad++; $display("FAIL same_cycle_status: got %h want 2", rd); end
    do_xfer(32'h8000_1004, 1'b0, 3'd2, 32'd0, 1'b0, 5'd0, rd, er, ok, eer, erd);
    n_cmp++;
    if (rd !== 32'd21) begin n_bad++; $display("FAIL same_cycle_result: got %h want 15", rd); end
  endtask

  task automatic test_errors();
    logic [31:0] rd, erd; bit er, ok, eer;
    logic [31:0] ea[6];
    bit ew[6];
    logic [2:0] es[6];
    logic [31:0] cfg0;
    ea = '{32'h8000_3000, 32'h9000_0000, 32'h8000_0004, 32'h8000_2010, 32'h8000_1000, 32'h8000_0006};
    ew = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    es = '{3'd2, 3'd2, 3'd3, 3'd3, 3'd2, 3'd2};
    pix_q.delete(); m_pix.delete();
    cfg0 = cfg;
    for (int i = 0; i < 6; i++) begin
      do_xfer(ea[i], ew[i], es[i], 32'hDEAD_BEEF, 1'b0, 5'd0, rd, er, ok, eer, erd);
      n_cmp++;
      if (er !== 1'b1 || eer !== 1'b1 || !ok) begin
        n_bad++; $display("FAIL err_resp[%0d]: addr=%h got err=%b ok=%b, want 1 1", i, ea[i], er, ok);
      end
    end
    repeat (2) @(posedge clk); #1;
    n_cmp++;
    if (cfg !== cfg0 || pix_q.size() != 0) begin
      n_bad++; $display("FAIL err_side_effect: cfg=%h (was %h) strobes=%0d, want unchanged and 0", cfg, cfg0, pix_q.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] aa[10], dd[10], er_rd[10];
    bit ww[10], ee[10];
    logic [2:0] ss[10];
    pix_q.delete(); m_pix.delete();
    for (int i = 0; i < 10; i++) begin
      ss[i] = 3'd2; dd[i] = $urandom; ww[i] = 1'b0;
      case ($urandom_range(0, 4))
        0: begin aa[i] = 32'h8000_0004; ww[i] = 1'b1; end
        1: aa[i] = 32'h8000_0004;
        2: begin aa[i] = 32'h8000_2000 + $urandom_range(0, 32'hBFF); ww[i] = 1'b1; ss[i] = 3'd0; end
        3: aa[i] = 32'h8000_1000;
        default: aa[i] = 32'h8000_2000 + $urandom_range(0, 32'hBFF);
      endcase
      model_step(aa[i], ww[i], ss[i], dd[i], 1'b0, 5'd0, ee[i], er_rd[i]);
    end
    @(posedge clk); #1;
    for (int i = 0; i <= 10; i++) begin
      if (i < 10) begin haddr = aa[i]; hwrite = ww[i]; hsize = ss[i]; htrans = T_NSEQ; end
      else begin htrans = T_IDLE; haddr = 32'd0; end
      if (i > 0) hwdata = dd[i-1];
      @(negedge clk);
      if (i > 0) begin
        n_cmp++;
        if (hready !== 1'b1 || hresp !== 1'b0 || (!ww[i-1] && hrdata !== er_rd[i-1])) begin
          n_bad++; $display("FAIL b2b[%0d]: addr=%h got hready=%b hresp=%b rd=%h, want 1 0 rd=%h",
                            i-1, aa[i-1], hready, hresp, hrdata, er_rd[i-1]);
        end
      end
      @(posedge clk); #1;
    end
    repeat (2) @(posedge clk); #1;
    n_cmp++;
    if (pix_q.size() != m_pix.size()) begin n_bad++; $display("FAIL b2b_pix_count: got %0d want %0d", pix_q.size(), m_pix.size()); end
    else foreach (m_pix[k]) if (pix_q[k] !== m_pix[k]) begin
      n_bad++; $display("FAIL b2b_pix[%0d]: got %h want %h", k, pix_q[k], m_pix[k]);
    end
    n_cmp++;
    if (cfg !== m_cfg) begin n_bad++; $display("FAIL b2b_cfg: got %h want %h", cfg, m_cfg); end
  endtask

  task automatic test_random();
    logic [31:0] rd, erd, a, wd; bit er, ok, eer, w, dp; logic [2:0] sz; logic [15:0] hi;
    pix_q.delete(); m_pix.delete();
    for (int i = 0; i < 60; i++) begin
      w = 1'($urandom_range(0, 1)); sz = 3'd2; wd = $urandom;
      dp = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 9))
        0: a = 32'h8000_0004;
        1: begin a = 32'h8000_0000; w = 1'b1; end
        2: a = 32'h8000_1000;
        3: a = 32'h8000_1004;
        4: begin a = 32'h8000_2000 + $urandom_range(0, 32'hBFF); w = 1'b1; sz = 3'($urandom_range(0, 3)); end
        5: begin a = 32'h8000_0000 + $urandom_range(1, 7); if (a[2:0] == 3'd4) a = a + 32'd1; end
        6: begin hi = 16'($urandom_range(0, 32'hFFFF)); if (hi == 16'h8000) hi = 16'h8001; a = {hi, 16'h0004}; end
        7: a = {16'h8000, 16'($urandom_range(32'h2C00, 32'hFFFF))};
        8: begin a = 32'h8000_2000 + $urandom_range(0, 32'hBFF); w = 1'b0; end
        default: begin a = 32'h8000_1000; w = 1'b0; sz = 3'($urandom_range(3, 7)); end
      endcase
      do_xfer(a, w, sz, wd, dp, 5'($urandom_range(0, 23)), rd, er, ok, eer, erd);
      n_cmp++;
      if (er !== eer || !ok || (!eer && !w && rd !== erd)) begin
        n_bad++; $display("FAIL rand[%0d]: addr=%h w=%b sz=%0d got err=%b ok=%b rd=%h, want err=%b rd=%h",
                          i, a, w, sz, er, ok, rd, eer, erd);
      end
    end
    repeat (2) @(posedge clk); #1;
    n_cmp++;
    if (pix_q.size() != m_pix.size()) begin n_bad++; $display("FAIL rand_pix_count: got %0d want %0d", pix_q.size(), m_pix.size()); end
    else foreach (m_pix[k]) if (pix_q[k] !== m_pix[k]) begin
      n_bad++; $display("FAIL rand_pix[%0d]: got %h want %h", k, pix_q[k], m_pix[k]);
    end
    n_cmp++;
    if (cfg !== m_cfg || start_cnt != m_starts) begin
      n_bad++; $display("FAIL rand_state: cfg=%h starts=%0d, want %h %0d", cfg, start_cnt, m_cfg, m_starts);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd, erd; bit er, ok, eer;
    do_xfer(32'h8000_0004, 1'b1, 3'd2, 32'h1234_5678, 1'b0, 5'd0, rd, er, ok, eer, erd);
    pix_q.delete(); m_pix.delete();
    @(posedge clk); #1;
    haddr = 32'h8000_2010; hwrite = 1'b1; hsize = 3'd0; htrans = T_NSEQ;
    @(posedge clk); #1;
    htrans = T_IDLE; hwdata = 32'h0000_005C;
    #2 resetn = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({hready, hresp, hrdata, cfg, start, pix_we, pix_ch, pix_addr, pix_data} !== {1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 2'd0, 10'd0, 8'd0}) begin
      n_bad++;
      $display("FAIL mid_reset_outputs: got hready=%b hresp=%b hrdata=%h cfg=%h start=%b we=%b ch=%0d addr=%0d data=%h, want 1 0 0 0 0 0 0 0 0",
               hready, hresp, hrdata, cfg, start, pix_we, pix_ch, pix_addr, pix_data);
    end
    @(posedge clk); #1; resetn = 1'b1;
    m_cfg = 32'd0; m_busy = 1'b0; m_done = 1'b0; m_ovr = 1'b0; m_result = 5'd0;
    repeat (2) @(posedge clk); #1;
    n_cmp++;
    if (pix_q.size() != 0) begin n_bad++; $display("FAIL mid_reset_strobe: got %0d strobes want 0", pix_q.size()); end
    do_xfer(32'h8000_1004, 1'b0, 3'd2, 32'd0, 1'b0, 5'd0, rd, er, ok, eer, erd);
    n_cmp++;
    if (er || rd !== 32'd0) begin n_bad++; $display("FAIL mid_reset_result: got %h want 0", rd); end
  endtask

  initial begin
    test_reset();
    test_cfg();
    test_pixel();
    test_start_done();
    test_overrun();
    test_done_with_start();
    test_errors();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
